// File: rtl/seq_det_pkg.sv
// Shared types and default widths for the serial sequence detector.
// Contents: FSM state enum and default pattern/match-counter widths.
// No ports; imported by seq_det_prog and seq_det_ctrl.
package seq_det_pkg;

    localparam int SEQ_DET_PAT_W_DEF = 4;
    localparam int SEQ_DET_CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_det_prog.sv
// Bit-history shifter, fill counter and pattern comparator for the sequence detector.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_clr clears history and fill;
//        i_en enables shifting (RUN only); i_w/i_w_valid serial bit; i_pattern latched target; o_z Mealy match.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int PAT_W = SEQ_DET_PAT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_w,
    input  logic             i_w_valid,
    input  logic [PAT_W-1:0] i_pattern,
    output logic             o_z
);

    localparam int                FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  w_window;
    logic              w_shift;

    // Candidate window: previous PAT_W-1 bits (oldest at MSB) plus the bit arriving now.
    assign w_window = {r_hist, i_w};
    assign w_shift  = i_en & i_w_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_shift) begin
            r_hist <= w_window[PAT_W-2:0];
            if (r_fill != FILL_FULL) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    // Only compare once the history holds real bits, so zero-initialised history
    // cannot fake a match on patterns with leading zeros.
    assign o_z = w_shift & (r_fill == FILL_FULL) & (w_window == i_pattern);

endmodule

// File: rtl/seq_det_ctrl.sv
// Session controller for a programmable serial sequence detector (IDLE/LOAD/RUN/DONE).
// Ports: i_start/i_abort control; i_pattern/i_match_target sampled on accepted start; i_w/i_w_valid data;
//        o_z Mealy match, o_busy (LOAD/RUN), o_done pulse, o_match_cnt, o_timeout.
// Optional RUN-cycle timeout is built only when SEQ_DET_CTRL_TIMEOUT_EN is defined.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W       = SEQ_DET_PAT_W_DEF,
    parameter int CNT_W       = SEQ_DET_CNT_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [CNT_W-1:0] i_match_target,
    input  logic             i_w,
    input  logic             i_w_valid,
    output logic             o_z,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic             o_timeout
);

    seq_state_t       r_state;
    logic [PAT_W-1:0] r_pattern;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_hit;
    logic             w_expire;
    logic             w_load;
    logic             w_run;
    logic             w_z;

    assign w_load    = (r_state == ST_LOAD);
    assign w_run     = (r_state == ST_RUN);
    assign w_cnt_inc = r_match_cnt + CNT_W'(1);
    // r_target already holds the effective target (0 mapped to 1 at latch time).
    assign w_hit     = (w_cnt_inc == r_target);

    seq_det_prog #(
        .PAT_W (PAT_W)
    ) u_prog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_load),
        .i_en      (w_run),
        .i_w       (i_w),
        .i_w_valid (i_w_valid),
        .i_pattern (r_pattern),
        .o_z       (w_z)
    );

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_cyc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc <= '0;
        end else if (w_load) begin
            r_cyc <= '0;
        end else if (w_run && !w_expire) begin
            r_cyc <= r_cyc + TO_W'(1);
        end
    end

    // Expires during the TIMEOUT_CYC-th RUN cycle, so DONE follows exactly TIMEOUT_CYC RUN cycles.
    assign w_expire = w_run && (r_cyc == TO_W'(TIMEOUT_CYC - 1));
`else
    // No counter in this build: never expires (parameter kept referenced for a shared interface).
    assign w_expire = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_pattern   <= '0;
            r_target    <= '0;
            r_match_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_pattern <= i_pattern;
                        r_target  <= (i_match_target == '0) ? CNT_W'(1) : i_match_target;
                        r_state   <= ST_LOAD;
                        r_busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_match_cnt <= '0;
                    r_timeout   <= 1'b0;
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Abort takes priority over any same-cycle match or expiry.
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (w_z) begin
                            r_match_cnt <= w_cnt_inc;
                        end
                        if (w_z && w_hit) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_expire) begin
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_z         = w_z;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_match_cnt = r_match_cnt;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl (PAT_W=4, CNT_W=4, TIMEOUT_CYC=8).
// Inputs change just after the falling edge; z is sampled 1ns later, registered outputs at the next falling edge.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic       i_abort;
    logic [3:0] i_pattern;
    logic [3:0] i_match_target;
    logic       i_w;
    logic       i_w_valid;
    logic       o_z;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_match_cnt;
    logic       o_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_det_ctrl #(
        .PAT_W       (4),
        .CNT_W       (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_pattern      (i_pattern),
        .i_match_target (i_match_target),
        .i_w            (i_w),
        .i_w_valid      (i_w_valid),
        .o_z            (o_z),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_match_cnt    (o_match_cnt),
        .o_timeout      (o_timeout)
    );

    // Drive one data cycle starting at a falling edge; returns z seen during that cycle.
    task automatic send_bit(input logic b, input logic v, output logic z_obs);
        i_w       = b;
        i_w_valid = v;
        #1 z_obs  = o_z;
        @(negedge clk);
        i_w       = 1'b0;
        i_w_valid = 1'b0;
    endtask

    // From a falling edge in IDLE: start pulse, one LOAD cycle, returns at a falling edge in RUN.
    task automatic start_session(input logic [3:0] pat, input logic [3:0] tgt);
        i_pattern      = pat;
        i_match_target = tgt;
        i_start        = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_pattern = '0;
        i_match_target = '0; i_w = 1'b0; i_w_valid = 1'b0;
        #1;
        n_checks++;
        if ({o_z, o_busy, o_done, o_match_cnt, o_timeout} !== 8'h00) begin
            $display("FAIL reset_outputs: got %b expected %b", {o_z, o_busy, o_done, o_match_cnt, o_timeout}, 8'h00);
            n_errors++;
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({o_busy, o_done} !== 2'b00) begin
            $display("FAIL reset_idle: got busy/done %b expected 00", {o_busy, o_done});
            n_errors++;
        end
    endtask

    task automatic test_single_match;
        logic [3:0] bits;
        logic [3:0] exp_z;
        logic       z;
        bits  = 4'b0011;
        exp_z = 4'b0001;
        start_session(4'b0011, 4'd1);
        n_checks++;
        if (o_busy !== 1'b1) begin
            $display("FAIL single_busy_run: got %b expected 1", o_busy);
            n_errors++;
        end
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i], 1'b1, z);
            n_checks++;
            if (z !== exp_z[i]) begin
                $display("FAIL single_z bit%0d: got %b expected %b", 3 - i, z, exp_z[i]);
                n_errors++;
            end
        end
        n_checks++;
        if ({o_busy, o_done, o_match_cnt, o_timeout} !== {1'b0, 1'b1, 4'd1, 1'b0}) begin
            $display("FAIL single_done: got busy,done,cnt,to %b expected %b", {o_busy, o_done, o_match_cnt, o_timeout}, {1'b0, 1'b1, 4'd1, 1'b0});
            n_errors++;
        end
        @(negedge clk);
        n_checks++;
        if ({o_busy, o_done, o_match_cnt} !== {1'b0, 1'b0, 4'd1}) begin
            $display("FAIL single_after_done: got busy,done,cnt %b expected %b", {o_busy, o_done, o_match_cnt}, {1'b0, 1'b0, 4'd1});
            n_errors++;
        end
    endtask

    task automatic test_overlap;
        logic [5:0]  bits;
        logic [5:0]  exp_z;
        logic [5:0]  exp_done;
        logic [23:0] exp_cnt;
        logic [3:0]  cnt_e;
        logic        z;
        bits     = 6'b010101;
        exp_z    = 6'b000101;
        exp_done = 6'b000001;
        exp_cnt  = {4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2};
        start_session(4'b0101, 4'd2);
        for (int i = 5; i >= 0; i--) begin
            send_bit(bits[i], 1'b1, z);
            cnt_e = exp_cnt[i*4 +: 4];
            n_checks++;
            if ({z, o_done, o_match_cnt} !== {exp_z[i], exp_done[i], cnt_e}) begin
                $display("FAIL overlap bit%0d: got z,done,cnt %b expected %b", 5 - i, {z, o_done, o_match_cnt}, {exp_z[i], exp_done[i], cnt_e});
                n_errors++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_gaps;
        logic [6:0] bits;
        logic [6:0] vlds;
        logic [6:0] exp_z;
        logic [6:0] exp_done;
        logic       z;
        bits     = 7'b0101101;
        vlds     = 7'b1010101;
        exp_z    = 7'b0000001;
        exp_done = 7'b0000001;
        start_session(4'b0011, 4'd0);
        for (int i = 6; i >= 0; i--) begin
            send_bit(bits[i], vlds[i], z);
            n_checks++;
            if ({z, o_done} !== {exp_z[i], exp_done[i]}) begin
                $display("FAIL gaps step%0d: got z,done %b expected %b", 6 - i, {z, o_done}, {exp_z[i], exp_done[i]});
                n_errors++;
            end
        end
        n_checks++;
        if (o_match_cnt !== 4'd1) begin
            $display("FAIL gaps_cnt: got %0d expected 1", o_match_cnt);
            n_errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        logic z;
        start_session(4'b0011, 4'd1);
        send_bit(1'b0, 1'b1, z);
        send_bit(1'b0, 1'b1, z);
        send_bit(1'b1, 1'b1, z);
        i_rst_n   = 1'b0;
        i_w       = 1'b1;
        i_w_valid = 1'b1;
        #1;
        n_checks++;
        if ({o_z, o_busy, o_done, o_match_cnt, o_timeout} !== 8'h00) begin
            $display("FAIL midrun_reset: got %b expected %b", {o_z, o_busy, o_done, o_match_cnt, o_timeout}, 8'h00);
            n_errors++;
        end
        @(negedge clk);
        i_w_valid = 1'b0;
        i_rst_n   = 1'b1;
        send_bit(1'b1, 1'b1, z);
        n_checks++;
        if ({z, o_busy, o_done} !== 3'b000) begin
            $display("FAIL midrun_after: got z,busy,done %b expected 000", {z, o_busy, o_done});
            n_errors++;
        end
    endtask

    task automatic test_abort;
        logic z;
        start_session(4'b0011, 4'd1);
        send_bit(1'b0, 1'b1, z);
        send_bit(1'b0, 1'b1, z);
        send_bit(1'b1, 1'b1, z);
        i_abort = 1'b1;
        send_bit(1'b1, 1'b1, z);
        i_abort = 1'b0;
        n_checks++;
        if ({o_busy, o_done, o_match_cnt} !== 6'b000000) begin
            $display("FAIL abort_match: got busy,done,cnt %b expected 000000", {o_busy, o_done, o_match_cnt});
            n_errors++;
        end
        @(negedge clk);
        n_checks++;
        if ({o_busy, o_done} !== 2'b00) begin
            $display("FAIL abort_no_done: got busy,done %b expected 00", {o_busy, o_done});
            n_errors++;
        end
        // Abort while in LOAD.
        i_pattern = 4'b1010; i_match_target = 4'd1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_busy, o_done} !== 2'b00) begin
            $display("FAIL abort_load: got busy,done %b expected 00", {o_busy, o_done});
            n_errors++;
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] bits;
        logic [6:0] exp_z;
        logic       z;
        start_session(4'b1001, 4'd1);
        send_bit(1'b1, 1'b1, z);
        send_bit(1'b0, 1'b1, z);
        send_bit(1'b0, 1'b1, z);
        send_bit(1'b1, 1'b1, z);
        n_checks++;
        if ({o_done, o_match_cnt} !== {1'b1, 4'd1}) begin
            $display("FAIL b2b_first: got done,cnt %b expected %b", {o_done, o_match_cnt}, {1'b1, 4'd1});
            n_errors++;
        end
        // Start during DONE must be ignored.
        i_pattern = 4'b0110; i_match_target = 4'd3; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_busy, o_match_cnt} !== {1'b0, 4'd1}) begin
            $display("FAIL b2b_start_in_done: got busy,cnt %b expected %b", {o_busy, o_match_cnt}, {1'b0, 4'd1});
            n_errors++;
        end
        start_session(4'b0110, 4'd3);
        n_checks++;
        if ({o_busy, o_match_cnt} !== {1'b1, 4'd0}) begin
            $display("FAIL b2b_load_clear: got busy,cnt %b expected %b", {o_busy, o_match_cnt}, {1'b1, 4'd0});
            n_errors++;
        end
        bits  = 7'b0110110;
        exp_z = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            if (i == 5) begin
                i_start   = 1'b1;
                i_pattern = 4'b1111;
            end
            send_bit(bits[i], 1'b1, z);
            i_start = 1'b0;
            n_checks++;
            if (z !== exp_z[i]) begin
                $display("FAIL b2b_z bit%0d: got %b expected %b", 6 - i, z, exp_z[i]);
                n_errors++;
            end
        end
        n_checks++;
        if ({o_busy, o_done, o_match_cnt} !== {1'b1, 1'b0, 4'd2}) begin
            $display("FAIL b2b_second: got busy,done,cnt %b expected %b", {o_busy, o_done, o_match_cnt}, {1'b1, 1'b0, 4'd2});
            n_errors++;
        end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        @(negedge clk);
    endtask

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        logic [7:0] bits;
        logic       z;
        start_session(4'b1111, 4'd1);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0, 1'b1, z);
            if (i == 6) begin
                n_checks++;
                if ({o_busy, o_done} !== 2'b10) begin
                    $display("FAIL timeout_early: got busy,done %b expected 10", {o_busy, o_done});
                    n_errors++;
                end
            end
        end
        n_checks++;
        if ({o_busy, o_done, o_match_cnt, o_timeout} !== {1'b0, 1'b1, 4'd0, 1'b1}) begin
            $display("FAIL timeout_expire: got busy,done,cnt,to %b expected %b", {o_busy, o_done, o_match_cnt, o_timeout}, {1'b0, 1'b1, 4'd0, 1'b1});
            n_errors++;
        end
        @(negedge clk);
        n_checks++;
        if ({o_done, o_timeout} !== 2'b01) begin
            $display("FAIL timeout_hold: got done,to %b expected 01", {o_done, o_timeout});
            n_errors++;
        end
        start_session(4'b1111, 4'd1);
        n_checks++;
        if (o_timeout !== 1'b0) begin
            $display("FAIL timeout_load_clear: got %b expected 0", o_timeout);
            n_errors++;
        end
        bits = 8'b00001111;
        for (int i = 7; i >= 0; i--) begin
            send_bit(bits[i], 1'b1, z);
        end
        n_checks++;
        if ({z, o_done, o_match_cnt, o_timeout} !== {1'b1, 1'b1, 4'd1, 1'b0}) begin
            $display("FAIL timeout_match_wins: got z,done,cnt,to %b expected %b", {z, o_done, o_match_cnt, o_timeout}, {1'b1, 1'b1, 4'd1, 1'b0});
            n_errors++;
        end
        @(negedge clk);
    endtask
`else
    task automatic test_no_timeout;
        logic z;
        start_session(4'b1111, 4'd1);
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b0, 1'b1, z);
        end
        n_checks++;
        if ({o_busy, o_done, o_timeout} !== 3'b100) begin
            $display("FAIL no_timeout: got busy,done,to %b expected 100", {o_busy, o_done, o_timeout});
            n_errors++;
        end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        n_checks++;
        if ({o_busy, o_done, o_timeout} !== 3'b000) begin
            $display("FAIL no_timeout_abort: got busy,done,to %b expected 000", {o_busy, o_done, o_timeout});
            n_errors++;
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_match();
        test_overlap();
        test_gaps();
        test_reset_mid_run();
        test_abort();
        test_back_to_back();
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, minimum 2.
REQ-002 Parameter CNT_W, default 4: width of match target and match counter.
REQ-003 Parameter TIMEOUT_CYC, default 255: RUN-state cycle limit, used only when SEQ_DET_CTRL_TIMEOUT_EN is defined.
REQ-004 Clock  in  1  rising-edge system clock.
REQ-005 Resetn  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  single-cycle request to arm a detection session.
REQ-007 abort  in  1  cancels the session in progress.
REQ-008 pattern  in  PAT_W  target bit pattern, MSB received first; sampled on accepted start.
REQ-009 match_target  in  CNT_W  number of matches ending the session; sampled on accepted start.
REQ-010 w  in  1  serial data bit.
REQ-011 w_valid  in  1  qualifies w; bits with w_valid=0 are ignored.
REQ-012 z  out  1  Mealy match indication, combinational from w/w_valid.
REQ-013 busy  out  1  high in LOAD and RUN.
REQ-014 done  out  1  one-cycle pulse at session end.
REQ-015 match_cnt  out  CNT_W  matches in current/last session.
REQ-016 timeout  out  1  last session ended by timeout.

Function
REQ-017 FSM states are IDLE, LOAD, RUN and DONE.
REQ-018 In IDLE, start=1 latches pattern and match_target and moves to LOAD; in all other states start is ignored.
REQ-019 LOAD lasts one cycle: clears bit history, bit-fill count, match_cnt and timeout; moves to RUN.
REQ-020 In RUN, each w_valid=1 cycle shifts w into a PAT_W-1 bit history; fill count saturates at PAT_W-1.
REQ-021 z=1 iff state is RUN, w_valid=1, fill count = PAT_W-1, and {history,w} equals the latched pattern; overlapping matches count.
REQ-022 A cycle with z=1 increments match_cnt at the clock edge.
REQ-023 If the incremented match_cnt equals the effective target, the next state is DONE; effective target is match_target, or 1 when match_target=0.
REQ-024 DONE asserts done=1 for exactly one cycle, then returns to IDLE; match_cnt and timeout hold until the next LOAD.
REQ-025 abort=1 in LOAD or RUN returns to IDLE next cycle with no done and no match_cnt update; abort wins over a same-cycle match.
REQ-026 z and busy are 0 outside RUN, and LOAD/RUN respectively; bits arriving in IDLE, LOAD or DONE are discarded.

Reset
REQ-027 Resetn=0 immediately forces IDLE, z=0, busy=0, done=0, match_cnt=0, timeout=0, history and latched registers =0, regardless of state.

Configuration
REQ-028 With SEQ_DET_CTRL_TIMEOUT_EN defined: a cycle counter cleared in LOAD counts RUN cycles; on reaching TIMEOUT_CYC without meeting the target, next state is DONE with timeout=1.
REQ-029 If the target is met in the same cycle the timeout expires, the match wins and timeout=0.
REQ-030 Without SEQ_DET_CTRL_TIMEOUT_EN: no counter is built, timeout is tied 0, and RUN waits indefinitely for matches or abort.

Structure
REQ-031 Package seq_det_pkg holds the FSM state enum and default PAT_W and CNT_W constants.
REQ-032 Sub-module seq_det_prog implements the shift history, fill count and pattern comparator producing z; seq_det_ctrl owns the FSM, counters and latches.

Verification
REQ-033 Start, pattern=0011, target=1; valid bits 0,0,1,1 -> z=1 on the 4th bit, match_cnt=1, done pulse one cycle later, busy=0 after.
REQ-034 Start, pattern=0101, target=2; bits 0,1,0,1,0,1 -> z on bits 4 and 6, match_cnt=2, done after bit 6.
REQ-035 Pattern=0011, target=0; bits 0,0,1,1 with w_valid=0 gap cycles interleaved -> gaps ignored, done after the first match, match_cnt=1.
REQ-036 Resetn=0 mid-RUN after bits 0,0,1 -> all outputs 0 immediately; a following 1 produces no z.
REQ-037 Abort in the same cycle as a matching bit -> no z count, no done, IDLE next cycle.
REQ-038 Macro defined, TIMEOUT_CYC=8, pattern=1111, bits all 0 -> done with timeout=1 after 8 RUN cycles; a match on the expiry cycle with target=1 -> timeout=0.
